// File: rtl/iq_deserializer.sv
// Serial IQ word deserializer: finds the 32-bit word boundary in a 2-bit/clk
// stream via I/Q sync markers, tracks lock, and queues good words in a FWFT FIFO.
module iq_deserializer #(
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_ERR    = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  rx_bits,
  input  logic        rd_en,
  output logic [31:0] rd_data,
  output logic        rd_dr,
  output logic        locked,
  output logic        overflow,
  output logic [15:0] sync_err_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = $clog2(MAX_ERR + 1);
  localparam logic [EW-1:0] ERR_LAST = EW'(MAX_ERR - 1);
  localparam logic [AW:0]   COUNT_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t          state, state_n;
  logic            phase, phase_n;
  logic [3:0]      bcnt, bcnt_n;
  logic [EW-1:0]   err_cnt, err_cnt_n;
  logic            push_req;
  logic            serr_inc;

  logic [32:0]     window;
  logic [31:0]     cand0, cand1, cand_sel;
  logic            good0, good1, good_sel;
  logic            boundary;

  logic [31:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            full, pop, push;

  // Bit history; rx_bits[1] arrived first so it lands one place higher.
  always_ff @(posedge clk) begin
    window <= {window[30:0], rx_bits};
  end

  assign cand0    = window[31:0];
  assign cand1    = window[32:1];
  assign good0    = (cand0[31:30] == 2'b10) && (cand0[15:14] == 2'b01);
  assign good1    = (cand1[31:30] == 2'b10) && (cand1[15:14] == 2'b01);
  assign cand_sel = phase ? cand1 : cand0;
  assign good_sel = phase ? good1 : good0;
  assign boundary = (bcnt == 4'hF);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= HUNT;
      phase        <= 1'b0;
      bcnt         <= 4'd0;
      err_cnt      <= '0;
      sync_err_cnt <= 16'd0;
    end else begin
      state   <= state_n;
      phase   <= phase_n;
      bcnt    <= bcnt_n;
      err_cnt <= err_cnt_n;
      if (serr_inc && (sync_err_cnt != 16'hFFFF)) begin
        sync_err_cnt <= sync_err_cnt + 16'd1;
      end
    end
  end

  // Boundary counter free-runs from the HUNT hit; wrap to 15 marks each word.
  always_comb begin
    state_n   = state;
    phase_n   = phase;
    bcnt_n    = bcnt + 4'd1;
    err_cnt_n = err_cnt;
    push_req  = 1'b0;
    serr_inc  = 1'b0;
    case (state)
      HUNT: begin
        bcnt_n    = 4'd0;
        err_cnt_n = '0;
        if (good0) begin
          phase_n = 1'b0;
          state_n = VERIFY;
        end else if (good1) begin
          phase_n = 1'b1;
          state_n = VERIFY;
        end
      end
      VERIFY: begin
        if (boundary) begin
          if (good_sel) begin
            state_n   = LOCKED;
            push_req  = 1'b1;
            err_cnt_n = '0;
          end else begin
            state_n = HUNT;
          end
        end
      end
      LOCKED: begin
        if (boundary) begin
          if (good_sel) begin
            push_req  = 1'b1;
            err_cnt_n = '0;
          end else begin
            serr_inc = 1'b1;
            if (err_cnt == ERR_LAST) begin
              err_cnt_n = '0;
              state_n   = HUNT;
            end else begin
              err_cnt_n = err_cnt + 1'b1;
            end
          end
        end
      end
      default: begin
        state_n = HUNT;
      end
    endcase
  end

  assign locked = (state == LOCKED);

  // Read side: rd_dr is valid, rd_en is ready; a word transfers on any edge
  // where both are high. rd_en with rd_dr low is ignored.
  assign full    = (count == COUNT_FULL);
  assign rd_dr   = (count != '0);
  assign rd_data = mem[rd_ptr];
  assign pop     = rd_en && rd_dr;
  assign push    = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= cand_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: doc/iq_deserializer.md
IQ_DESERIALIZER -- requirements
Module: iq_deserializer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, output FIFO depth in words, a power of 2 and at least 4.
REQ-002 SHALL have parameter MAX_ERR, default 4, the number of consecutive bad words that drops lock.
REQ-003 SHALL have port clk, input, 1 bit, sole clock; every flop is clocked on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit, reset; synchronous, active-low.
REQ-005 SHALL have port rx_bits, input, 2 bits, two serial bits per clk from the DDR capture; rx_bits[1] is the earlier bit.
REQ-006 SHALL have port rd_en, input, 1 bit, pops the FIFO head at the edge where it is high.
REQ-007 SHALL have port rd_data, output, 32 bits, FIFO head word (first-word-fall-through); valid only while rd_dr=1.
REQ-008 SHALL have port rd_dr, output, 1 bit, FIFO non-empty.
REQ-009 SHALL have port locked, output, 1 bit, high while the state is LOCKED.
REQ-010 SHALL have port overflow, output, 1 bit, sticky; a word was dropped because the FIFO was full.
REQ-011 SHALL have port sync_err_cnt, output, 16 bits, saturating count of bad words seen in LOCKED.

Function
REQ-012 SHALL shift the bits in MSB-first: each word bit 31 is received first, and a 33-bit history window holds the most recent bits.
REQ-013 SHALL define a word as good when bits[31:30]=2'b10 (I_SYNC) and bits[15:14]=2'b01 (Q_SYNC); bits [29:17]=I, [16]=ctl, [13:1]=Q, [0]=ctl.
REQ-014 SHALL provide two candidates each cycle: phase 0 = window[31:0] and phase 1 = window[32:1].
REQ-015 SHALL implement three states: HUNT, VERIFY and LOCKED.
REQ-016 HUNT SHALL check both candidates every cycle; on a good phase-0 candidate it SHALL record phase 0, otherwise on a good phase-1 candidate it SHALL record phase 1.
REQ-017 On recording a phase in HUNT, the state SHALL go to VERIFY, clear the 4-bit word-boundary counter, and discard that word.
REQ-018 SHALL evaluate the candidate at the recorded phase only at a word boundary, which occurs every 16 clocks after the HUNT hit.
REQ-019 VERIFY SHALL go to LOCKED and push the word if the boundary word is good, and SHALL go to HUNT otherwise.
REQ-020 LOCKED SHALL push a good boundary word and clear the consecutive-error counter.
REQ-021 LOCKED SHALL discard a bad boundary word, increment the consecutive-error counter and increment sync_err_cnt, holding sync_err_cnt at 0xFFFF.
REQ-022 LOCKED SHALL go to HUNT when the consecutive-error counter reaches MAX_ERR, and locked SHALL fall the same edge.
REQ-023 SHALL write a pushed word to the FIFO at the edge after the edge that sampled the word's final bit; rd_dr SHALL be high the cycle following that write.
REQ-024 SHALL keep rd_data equal to the head entry combinationally, and SHALL advance the head on an edge where rd_en=1 and the FIFO is non-empty.
REQ-025 SHALL ignore rd_en when the FIFO is empty: no pointer movement and no error.
REQ-026 SHALL drop a push when the FIFO is full and no pop occurs that edge; overflow SHALL set and stay set until reset.
REQ-027 When the FIFO is full and a push and a pop occur at the same edge, both SHALL take effect with the count unchanged and no overflow.
REQ-028 SHALL wrap the FIFO pointers modulo FIFO_DEPTH and keep the count width at log2(FIFO_DEPTH)+1.
REQ-029 SHALL return words in push order; the consumer may hold rd_en for one cycle per word and re-poll rd_dr.

Reset
REQ-030 When reset_n=0 at an edge, the block SHALL enter HUNT, empty the FIFO, and clear rd_dr, locked, overflow, sync_err_cnt, the phase, and the boundary and error counters; the history window is not reset.
REQ-031 A reset mid-word or mid-lock SHALL discard partial and queued words; rd_dr=0 and locked=0 the cycle after the reset edge.
REQ-032 SHALL need no recovery cycles after reset: the first cycle with reset_n=1 evaluates HUNT.

Verification
REQ-033 Clean stream, phase 0, words 0x8000_4000+2n (n=0..9) -> locked high 16 clocks after the first HUNT hit; word n=0 dropped, n=1..9 read out in order; sync_err_cnt=0.
REQ-034 Same stream preceded by one extra bit (phase 1) -> lock at phase 1 with identical output words.
REQ-035 Locked, then I_SYNC corrupted on 3 consecutive words, then a good word -> locked stays 1, sync_err_cnt=3; 4 consecutive bad words -> locked falls at the 4th boundary.
REQ-036 Locked with no reads for 20 good words -> rd_dr=1, overflow=1; draining yields exactly the first 16 words in order, then rd_dr=0.
REQ-037 Full FIFO with rd_en=1 at the same edge as a push -> overflow stays 0 and the newest word is retained at the tail.
REQ-038 Reset pulse while locked with 5 words queued -> rd_dr=0 and locked=0 the next cycle; rd_en pulses on the empty FIFO are ignored.
